// File: rtl/one_shot_if.sv
// Purpose: trigger/pulse bundle for the one_shot monostable.
// Signals:
//   in   - trigger input; a rising edge fires a pulse
//   out  - registered pulse output, high while a pulse is active
//   dur  - pulse length in clk cycles (unsigned)
//   load - level-sensitive; dur is captured on every edge it is high
// Modports: master drives in/dur/load and observes out; slave is the one_shot.
interface one_shot_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in;
  logic             out;
  logic [WIDTH-1:0] dur;
  logic             load;

  modport master (
    output in,
    output dur,
    output load,
    input  out
  );

  modport slave (
    input  in,
    input  dur,
    input  load,
    output out
  );
endinterface

// File: rtl/one_shot.sv
// Purpose: programmable, non-retriggerable monostable. A rising edge on
//   bus.in produces a high level on bus.out lasting dur_reg clock cycles.
//   dur_reg is loaded from bus.dur whenever bus.load is high.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high reset
//   bus   - one_shot_if slave modport (in, out, dur, load)
module one_shot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  one_shot_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t           state;
  logic             in_d;
  logic             out_q;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] dur_reg;
  logic             trig;

  // Rising-edge detect on the trigger input.
  assign trig = bus.in & ~in_d;

  // in_d tracks in even during reset so a level held through reset cannot fire.
  always_ff @(posedge clk) begin
    in_d <= bus.in;
    if (reset) begin
      state   <= IDLE;
      out_q   <= 1'b0;
      cnt     <= '0;
      dur_reg <= '0;
    end else begin
      // A new length only affects the next trigger; the FSM reads the old value.
      if (bus.load) begin
        dur_reg <= bus.dur;
      end
      case (state)
        IDLE: begin
          if (trig && (dur_reg != '0)) begin
            state <= ACTIVE;
            out_q <= 1'b1;
            cnt   <= dur_reg - WIDTH'(1);
          end
        end
        ACTIVE: begin
          // Triggers are ignored here, including one on the terminal edge.
          if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
          end else begin
            state <= IDLE;
            out_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          out_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_one_shot.sv
// Purpose: self-checking bench for one_shot. A cycle-level reference model
//   tracks the number of pulse cycles still owed and the programmed length;
//   every clock the DUT output is compared against it. Directed scenarios
//   cover the documented cases, then a randomized run follows.
module tb_one_shot;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic reset;

  always #10 clk = ~clk;

  one_shot_if #(.WIDTH(WIDTH)) bus ();

  one_shot #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining high cycles, programmed length, previous in.
  int unsigned rem_m   = 0;
  int unsigned dur_m   = 0;
  bit          prev_in = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive on the falling edge, advance the model on the rising
  // edge, compare shortly after.
  task automatic step(input string tag, input bit r, input bit i, input bit l,
                      input int unsigned d, output bit o);
    bit          rise;
    bit          was_active;
    int unsigned old_dur;
    @(negedge clk);
    reset    = r;
    bus.in   = i;
    bus.load = l;
    bus.dur  = WIDTH'(d);
    @(posedge clk);
    rise    = i & ~prev_in;
    prev_in = i;
    if (r) begin
      rem_m = 0;
      dur_m = 0;
    end else begin
      old_dur    = dur_m;
      was_active = (rem_m != 0);
      if (l) dur_m = d;
      if (was_active) rem_m = rem_m - 1;
      else if (rise && old_dur != 0) rem_m = old_dur;
    end
    #1;
    o = bus.out;
    check(tag, 32'(bus.out), 32'(rem_m != 0));
  endtask

  // Trigger with the current length, then count high cycles over a window.
  task automatic measure(input string tag, input int unsigned win,
                         input int unsigned exp_len);
    bit          o;
    int unsigned hi = 0;
    step(tag, 1'b0, 1'b1, 1'b0, 0, o);
    if (o) hi++;
    for (int k = 0; k < int'(win); k++) begin
      step(tag, 1'b0, 1'b0, 1'b0, 0, o);
      if (o) hi++;
    end
    check({tag, "_len"}, hi, exp_len);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit          o;
    int unsigned hi;
    bit          r, i, l;
    int unsigned d;

    reset    = 1'b1;
    bus.in   = 1'b0;
    bus.load = 1'b0;
    bus.dur  = '0;

    // 1: reset, then a trigger with dur_reg=0 gives nothing
    for (int k = 0; k < 3; k++) step("reset", 1'b1, 1'b0, 1'b0, 0, o);
    check("reset_out", 32'(o), 32'(0));
    step("zero_dur", 1'b0, 1'b1, 1'b0, 0, o);
    for (int k = 0; k < 4; k++) step("zero_dur", 1'b0, 1'b0, 1'b0, 0, o);

    // 2: dur=2, in held high 3 cycles
    step("dur2", 1'b0, 1'b0, 1'b1, 2, o);
    hi = 0;
    for (int k = 0; k < 3; k++) begin
      step("dur2", 1'b0, 1'b1, 1'b0, 0, o);
      if (o) hi++;
    end
    check("dur2_last_while_in_high", 32'(o), 32'(0));
    for (int k = 0; k < 3; k++) begin
      step("dur2", 1'b0, 1'b0, 1'b0, 0, o);
      if (o) hi++;
    end
    check("dur2_len", hi, 2);

    // 3: dur=5, second rising edge during the pulse does not extend it
    step("noretrig", 1'b0, 1'b0, 1'b1, 5, o);
    hi = 0;
    step("noretrig", 1'b0, 1'b1, 1'b0, 0, o); if (o) hi++;
    step("noretrig", 1'b0, 1'b0, 1'b0, 0, o); if (o) hi++;
    step("noretrig", 1'b0, 1'b1, 1'b0, 0, o); if (o) hi++;
    for (int k = 0; k < 8; k++) begin
      step("noretrig", 1'b0, 1'b0, 1'b0, 0, o);
      if (o) hi++;
    end
    check("noretrig_len", hi, 5);

    // 4: reload during a pulse applies to the next trigger only
    step("reload", 1'b0, 1'b0, 1'b1, 3, o);
    hi = 0;
    step("reload", 1'b0, 1'b1, 1'b1, 9, o); if (o) hi++;  // load+trig: old length
    step("reload", 1'b0, 1'b0, 1'b1, 7, o); if (o) hi++;
    for (int k = 0; k < 6; k++) begin
      step("reload", 1'b0, 1'b0, 1'b0, 0, o);
      if (o) hi++;
    end
    check("reload_first_len", hi, 3);
    measure("reload_second", 12, 7);

    // 5: reset mid-pulse, in held high across reset release
    step("rst_mid", 1'b0, 1'b0, 1'b1, 4, o);
    step("rst_mid", 1'b0, 1'b1, 1'b0, 0, o);
    step("rst_mid", 1'b0, 1'b1, 1'b0, 0, o);
    step("rst_mid", 1'b1, 1'b1, 1'b0, 0, o);
    check("rst_mid_kill", 32'(o), 32'(0));
    step("rst_mid", 1'b1, 1'b1, 1'b0, 0, o);
    step("rst_mid", 1'b0, 1'b1, 1'b1, 4, o);
    hi = 0;
    for (int k = 0; k < 4; k++) begin
      step("rst_hold", 1'b0, 1'b1, 1'b0, 0, o);
      if (o) hi++;
    end
    check("rst_hold_no_fire", hi, 0);
    step("rst_hold", 1'b0, 1'b0, 1'b0, 0, o);
    measure("rst_refire", 8, 4);

    // 6: extreme lengths
    step("max", 1'b0, 1'b0, 1'b1, 255, o);
    measure("max", 300, 255);
    step("min", 1'b0, 1'b0, 1'b1, 1, o);
    measure("min", 5, 1);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 99) == 0);
      i = ($urandom_range(0, 9) < 3);
      l = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 255)
                                       : $urandom_range(0, 10);
      step("random", r, i, l, d, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
